// File: rtl/paddle_ctrl.sv
// Per-player paddle: debounced up/down buttons move yRef once per frame tick, clamped to the playfield.
// Bounds are combinational from yRef (visible the cycle after the tick); buttons accepted 2+DEBOUNCE cycles after settling.
module paddle_ctrl #(
  parameter int X_REF    = 80,
  parameter int Y_INIT   = 240,
  parameter int HALF_W   = 25,
  parameter int HALF_H   = 33,
  parameter int STEP     = 4,
  parameter int Y_MIN    = 33,
  parameter int Y_MAX    = 446,
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       freeze,
  input  logic       recenter,
  output logic [8:0] yRef,
  output logic [9:0] leftBound,
  output logic [9:0] rightBound,
  output logic [8:0] topBound,
  output logic [8:0] bottomBound,
  output logic       moved
);

  localparam int            CW        = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [9:0]    Y_MIN_C   = 10'(Y_MIN);
  localparam logic [9:0]    Y_MAX_C   = 10'(Y_MAX);
  localparam logic [9:0]    STEP_C    = 10'(STEP);
  localparam logic [9:0]    SUB_LIMIT = 10'(Y_MIN + STEP);

  typedef enum logic {STABLE, COUNTING} db_state_e;

  // Index 0 is the up button, index 1 the down button.
  db_state_e     state_q [2];
  db_state_e     state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic          se_q, se_d;
  logic [8:0]    yref_q, yref_d;
  logic          moved_q, moved_d;

  logic          tick;
  logic          go_up;
  logic          go_down;
  logic [9:0]    y_ext;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      se_q    <= 1'b0;
      yref_q  <= 9'(Y_INIT);
      moved_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      se_q    <= se_d;
      yref_q  <= yref_d;
      moved_q <= moved_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        STABLE:   if (sync2_q[i] != deb_q[i]) state_d[i] = COUNTING;
        COUNTING: if ((sync2_q[i] == deb_q[i]) || (cnt_q[i] == CNT_LAST)) state_d[i] = STABLE;
      endcase
    end
  end

  // A bounce back to the debounced level drops the count to zero.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      deb_d[i] = deb_q[i];
      case (state_q[i])
        STABLE: begin
          if (sync2_q[i] != deb_q[i]) cnt_d[i] = CW'(1);
        end
        COUNTING: begin
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    sync1_d = {btn_down, btn_up};
    sync2_d = sync1_q;
    se_d    = screenEnd;
    tick    = screenEnd & ~se_q;
    go_up   = deb_q[0] & ~deb_q[1];
    go_down = deb_q[1] & ~deb_q[0];
    y_ext   = {1'b0, yref_q};
    yref_d  = yref_q;
    if (recenter) begin
      yref_d = 9'(Y_INIT);
    end else if (tick && !freeze) begin
      // Compare before subtracting so the 10-bit difference can never wrap.
      if (go_up)
        yref_d = (y_ext >= SUB_LIMIT) ? 9'(y_ext - STEP_C) : 9'(Y_MIN_C);
      else if (go_down)
        yref_d = ((y_ext + STEP_C) <= Y_MAX_C) ? 9'(y_ext + STEP_C) : 9'(Y_MAX_C);
    end
    moved_d = (yref_d != yref_q);
  end

  assign yRef        = yref_q;
  assign moved       = moved_q;
  assign leftBound   = 10'(X_REF - HALF_W);
  assign rightBound  = 10'(X_REF + HALF_W);
  assign topBound    = yref_q - 9'(HALF_H);
  assign bottomBound = yref_q + 9'(HALF_H);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: vector table of button/freeze/recenter frames plus multi-cycle corner sequences.
module tb_paddle_ctrl;

  logic       clock = 1'b0;
  logic       reset, screenEnd, btn_up, btn_down, freeze, recenter;
  logic [8:0] yRef, topBound, bottomBound;
  logic [9:0] leftBound, rightBound;
  logic       moved;

  always #5 clock = ~clock;

  paddle_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .screenEnd   (screenEnd),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .freeze      (freeze),
    .recenter    (recenter),
    .yRef        (yRef),
    .leftBound   (leftBound),
    .rightBound  (rightBound),
    .topBound    (topBound),
    .bottomBound (bottomBound),
    .moved       (moved)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [8:0] y;
    logic       m;
    logic [8:0] top;
    logic [8:0] bot;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       u, d, f, rc;
    logic [8:0] y;
    logic       m;
  } vec_t;

  vec_t vt[10];

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmp(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input logic [8:0] y, input logic m);
    exp_t e;
    e.y   = y;
    e.m   = m;
    e.top = y - 9'd33;
    e.bot = y + 9'd33;
    sb.push_back(e);
  endtask

  task automatic chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got yRef %0d", name, yRef);
      return;
    end
    e = sb.pop_front();
    cmp({name, ".yRef"},   yRef,        e.y);
    cmp({name, ".moved"},  moved,       e.m);
    cmp({name, ".top"},    topBound,    e.top);
    cmp({name, ".bottom"}, bottomBound, e.bot);
  endtask

  task automatic set_btns(input logic u, input logic d);
    btn_up   = u;
    btn_down = d;
    cyc(20);
  endtask

  task automatic pulse();
    screenEnd = 1'b1;
    cyc();
    screenEnd = 1'b0;
    cyc();
  endtask

  task automatic tick_chk(input string name, input logic [8:0] y, input logic m, input logic rc);
    push(y, m);
    screenEnd = 1'b1;
    recenter  = rc;
    cyc();
    chk(name);
    recenter  = 1'b0;
    screenEnd = 1'b0;
    cyc();
    cmp({name, ".moved_clear"}, moved, 0);
  endtask

  task automatic do_recenter();
    recenter = 1'b1;
    cyc();
    recenter = 1'b0;
    cyc();
  endtask

  initial begin
    int pulses;

    //           u     d     f     rc    y       m
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd236, 1'b1};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd240, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd244, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd244, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd244, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd244, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'd240, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd240, 1'b0};
    vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd240, 1'b0};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd236, 1'b1};

    reset = 1'b0; screenEnd = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    freeze = 1'b0; recenter = 1'b0;
    cyc(2);
    push(9'd240, 1'b0);
    chk("reset");
    cmp("reset.left",  leftBound,  55);
    cmp("reset.right", rightBound, 105);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 10; i++) begin
      freeze = vt[i].f;
      set_btns(vt[i].u, vt[i].d);
      tick_chk($sformatf("vec%0d", i), vt[i].y, vt[i].m, vt[i].rc);
      freeze = 1'b0;
    end

    // screenEnd held for three cycles must give a single move.
    set_btns(1'b0, 1'b0);
    do_recenter();
    set_btns(1'b1, 1'b0);
    pulses = 0;
    screenEnd = 1'b1;
    repeat (3) begin
      cyc();
      if (moved) pulses++;
    end
    screenEnd = 1'b0;
    repeat (2) begin
      cyc();
      if (moved) pulses++;
    end
    cmp("held_se.pulses", pulses, 1);
    push(9'd236, 1'b0);
    chk("held_se");

    // Short press is rejected by the debouncer.
    set_btns(1'b0, 1'b0);
    do_recenter();
    btn_up = 1'b1;
    cyc(5);
    btn_up = 1'b0;
    cyc(20);
    tick_chk("glitch", 9'd240, 1'b0, 1'b0);

    // Top clamp.
    set_btns(1'b1, 1'b0);
    repeat (60) pulse();
    push(9'd33, 1'b0);
    chk("at_min");
    set_btns(1'b0, 1'b1);
    tick_chk("to37", 9'd37, 1'b1, 1'b0);
    set_btns(1'b1, 1'b0);
    tick_chk("clamp33", 9'd33, 1'b1, 1'b0);
    tick_chk("hold33",  9'd33, 1'b0, 1'b0);

    // Bottom clamp.
    set_btns(1'b0, 1'b1);
    repeat (110) pulse();
    push(9'd446, 1'b0);
    chk("at_max");
    cmp("at_max.bottom479", bottomBound, 479);
    tick_chk("hold_max", 9'd446, 1'b0, 1'b0);

    // Reset partway through a debounce count forces a full recount.
    set_btns(1'b0, 1'b0);
    btn_up = 1'b1;
    cyc(8);
    reset = 1'b0;
    cyc();
    push(9'd240, 1'b0);
    chk("mid_reset");
    reset = 1'b1;
    cyc(16);
    tick_chk("recount_early", 9'd240, 1'b0, 1'b0);
    tick_chk("recount_done",  9'd236, 1'b1, 1'b0);

    // Recenter beats a simultaneous tick with up held.
    do_recenter();
    repeat (35) pulse();
    push(9'd100, 1'b0);
    chk("at100");
    tick_chk("recenter_tick", 9'd240, 1'b1, 1'b1);

    cmp("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
